// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the kernel deadlock block detector.
// Optional feature macro: DEADLOCK_DETECT_STICKY_EN (see deadlock_block_detector.sv).
package deadlock_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWatch   = 2'd1,
    StBlocked = 2'd2
  } state_e;

  localparam int unsigned DefaultThresh = 16;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/stall_vec_tracker.sv
// Derives the stall condition from the raw blocking/idle vectors and remembers the previous
// vector so the FSM can tell a frozen stall from one that is still making progress.
module stall_vec_tracker #(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_INST = 2,
  parameter int unsigned N_IBLK = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_IBLK-1:0]        inst_block_sigs,
  output logic                     stall,
  output logic                     changed,
  output logic [N_AXIS+N_IBLK-1:0] snap_val
);

  localparam int unsigned VecW = N_AXIS + N_INST + N_IBLK;

  logic [VecW-1:0] vec;
  logic [VecW-1:0] prev_vec_q;

  assign vec      = {inst_block_sigs, inst_idle_sigs, axis_block_sigs};
  // Someone is waiting, and the kernel is not simply finished with every instance idle.
  assign stall    = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
  assign changed  = (vec != prev_vec_q);
  assign snap_val = {inst_block_sigs, axis_block_sigs};

  // Previous-cycle vector, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_vec_q <= '0;
    end else begin
      prev_vec_q <= vec;
    end
  end

endmodule

// File: rtl/deadlock_block_detector.sv
// Qualifies a raw kernel stall into a confirmed block: the stall must persist with an unchanged
// signal vector for THRESH consecutive cycles. Define DEADLOCK_DETECT_STICKY_EN to latch BLOCKED
// until reset instead of releasing when the stall clears or moves.
module deadlock_block_detector
  import deadlock_pkg::*;
#(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_INST = 2,
  parameter int unsigned N_IBLK = 1,
  parameter int unsigned THRESH = DefaultThresh,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_IBLK-1:0]        inst_block_sigs,
  output logic                     block,
  output logic                     block_rise,
  output logic [N_AXIS+N_IBLK-1:0] block_snapshot,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned SnapW  = N_AXIS + N_IBLK;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             stall;
  logic             changed;
  logic [SnapW-1:0] snap_val;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             block_q, block_d;
  logic             rise_q, rise_d;
  logic [SnapW-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] cnt_inc;

  stall_vec_tracker #(
    .N_AXIS (N_AXIS),
    .N_INST (N_INST),
    .N_IBLK (N_IBLK)
  ) u_tracker (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .stall           (stall),
    .changed         (changed),
    .snap_val        (snap_val)
  );

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt_q), 32'(CntMax)));

  // Next-state logic: count frozen-stall cycles and enter BLOCKED when the count hits THRESH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    rise_d  = 1'b0;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle, StWatch: begin
        if (!stall) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // Entry from IDLE and any progress in WATCH both restart the run at 1.
          cnt_d   = (state_q == StIdle || changed) ? CNT_W'(1) : cnt_inc;
          state_d = StWatch;
          if (32'(cnt_d) == THRESH) begin
            state_d = StBlocked;
            block_d = 1'b1;
            rise_d  = 1'b1;
            snap_d  = snap_val;
          end
        end
      end
      StBlocked: begin
`ifdef DEADLOCK_DETECT_STICKY_EN
        cnt_d = stall ? cnt_inc : '0;
`else
        if (!stall || changed) begin
          state_d = StIdle;
          block_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: begin
        state_d = StIdle;
        block_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      block_q <= 1'b0;
      rise_q  <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      rise_q  <= rise_d;
      snap_q  <= snap_d;
    end
  end

  assign block          = block_q;
  assign block_rise     = rise_q;
  assign block_snapshot = snap_q;
  assign stall_cnt      = cnt_q;

endmodule
